motor_ramp_pwm: RTL and testbench

Parametrised successor of the single-speed two-motor driver. It drives CH H-bridge channels, each with its own PWM duty and direction pair. Duty changes are slew-limited (soft ramp). Direction reversals are sequenced as ramp-down, then dead-time with the bridge off, then restart. It sits between the game-state/mode decode logic and the motor driver pins.

---
 rtl/motor_ramp_pwm.sv | 151 +++++++++++++++
 tb/tb_motor_ramp_pwm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_pwm.sv
// Multi-channel H-bridge driver with slew-limited PWM duty
// and reversal sequencing through ramp-down and dead-time.
module motor_ramp_pwm #(
  parameter int CH           = 2,
  parameter int DUTY_W       = 10,
  parameter int PERIOD       = 4000,
  parameter int RAMP_STEP    = 8,
  parameter int DEAD_PERIODS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [CH*DUTY_W-1:0] cmd_duty,
  input  logic [CH-1:0]        cmd_dir,
  output logic [CH-1:0]        pwm,
  output logic [2*CH-1:0]      in_pair,
  output logic [CH*DUTY_W-1:0] cur_duty,
  output logic [CH-1:0]        busy
);

  localparam int CW = $clog2(PERIOD);
  localparam int PW = DUTY_W + $clog2(PERIOD + 1);
  localparam int DW = $clog2(DEAD_PERIODS + 1);
  localparam logic [DUTY_W:0] STEP = (DUTY_W + 1)'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RAMP_DN,
    DEAD
  } state_t;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t            st, st_n;
    logic [DUTY_W-1:0] cur, cur_n;
    logic              dir, dir_n;
    logic [1:0]        inp, inp_n;
    logic [DW-1:0]     dead, dead_n;
    logic              pwm_q;
    logic [DUTY_W-1:0] tgt;
    logic [DUTY_W:0]   gap_up, gap_dn;
    logic [DUTY_W-1:0] toward, dn_sat;
    logic [PW-1:0]     prod, thr;
    logic              same_dir;

    assign tgt = enable ? cmd_duty[g*DUTY_W +: DUTY_W] : '0;
    assign same_dir = (cmd_dir[g] == dir);
    assign gap_up = {1'b0, tgt} - {1'b0, cur};
    assign gap_dn = {1'b0, cur} - {1'b0, tgt};

    // Saturating step toward the target, never overshooting it
    always_comb begin
      toward = tgt;
      if (tgt > cur) begin
        if (gap_up > STEP) toward = cur + STEP[DUTY_W-1:0];
      end else if (cur > tgt) begin
        if (gap_dn > STEP) toward = cur - STEP[DUTY_W-1:0];
      end
    end

    assign dn_sat = ({1'b0, cur} > STEP) ? cur - STEP[DUTY_W-1:0] : '0;

    always_comb begin
      st_n   = st;
      cur_n  = cur;
      dir_n  = dir;
      inp_n  = inp;
      dead_n = dead;
      if (tick) begin
        unique case (st)
          IDLE: begin
            if (tgt != '0) begin
              st_n  = RUN;
              dir_n = cmd_dir[g];
              inp_n = cmd_dir[g] ? 2'b10 : 2'b01;
            end
          end
          RUN: begin
            if (tgt == '0 || !same_dir) st_n = RAMP_DN;
            else cur_n = toward;
          end
          RAMP_DN: begin
            if (tgt != '0 && same_dir) begin
              st_n  = RUN;
              cur_n = toward;
            end else begin
              cur_n = dn_sat;
              if (dn_sat == '0) begin
                st_n   = DEAD;
                inp_n  = 2'b00;
                dead_n = DW'(DEAD_PERIODS);
              end
            end
          end
          DEAD: begin
            dead_n = dead - DW'(1);
            if (dead == DW'(1)) st_n = IDLE;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st   <= IDLE;
        cur  <= '0;
        dir  <= 1'b0;
        inp  <= 2'b00;
        dead <= '0;
      end else begin
        st   <= st_n;
        cur  <= cur_n;
        dir  <= dir_n;
        inp  <= inp_n;
        dead <= dead_n;
      end
    end

    assign prod = PW'(cur) * PW'(PERIOD);
    assign thr  = prod >> DUTY_W;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pwm_q <= 1'b0;
      end else begin
        pwm_q <= (PW'(cnt) < thr);
      end
    end

    assign pwm[g]                         = pwm_q;
    assign in_pair[2*g +: 2]              = inp;
    assign cur_duty[g*DUTY_W +: DUTY_W]   = cur;
    assign busy[g]                        = (st != IDLE);
  end

endmodule

// File: tb/tb_motor_ramp_pwm.sv
// Scoreboard bench for motor_ramp_pwm: per-tick expectations
// are queued by the driver and checked by a monitor.
module tb_motor_ramp_pwm;
  localparam int P = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [19:0] cmd_duty = '0;
  logic [1:0]  cmd_dir = '0;
  logic [1:0]  pwm;
  logic [3:0]  in_pair;
  logic [19:0] cur_duty;
  logic [1:0]  busy;

  motor_ramp_pwm #(
    .CH(2), .DUTY_W(10), .PERIOD(P),
    .RAMP_STEP(8), .DEAD_PERIODS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cmd_duty(cmd_duty), .cmd_dir(cmd_dir),
    .pwm(pwm), .in_pair(in_pair),
    .cur_duty(cur_duty), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c0;
    int c1;
    int ip;
    int b;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hi0 = 0;
  int   hi1 = 0;
  int   prev0 = 0;
  int   prev1 = 0;
  logic [3:0] prev_ip = '0;
  event tick_ev;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      exp_t e;
      #1;
      cyc++;
      hi0 += int'(pwm[0]);
      hi1 += int'(pwm[1]);
      for (int c = 0; c < 2; c++) begin
        if (in_pair[2*c +: 2] != prev_ip[2*c +: 2]) begin
          total++;
          if (in_pair[2*c +: 2] != 2'b00 &&
              prev_ip[2*c +: 2] != 2'b00) begin
            bad++;
            $display("FAIL dir_swap ch%0d actual=%b->%b required via 00",
                     c, prev_ip[2*c +: 2], in_pair[2*c +: 2]);
          end
        end
      end
      prev_ip = in_pair;
      if (cyc % P == 0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow actual=empty required=entry");
        end else begin
          e = q.pop_front();
          chk("cur0", int'(cur_duty[9:0]), e.c0);
          chk("cur1", int'(cur_duty[19:10]), e.c1);
          chk("in_pair", int'(in_pair), e.ip);
          chk("busy", int'(busy), e.b);
          chk("hi0", hi0, (prev0 * P) >> 10);
          chk("hi1", hi1, (prev1 * P) >> 10);
          prev0 = e.c0;
          prev1 = e.c1;
        end
        hi0 = 0;
        hi1 = 0;
        -> tick_ev;
      end
    end
  end

  task automatic tk(input int c0, input int c1,
                    input int ip, input int b);
    exp_t e;
    e.c0 = c0;
    e.c1 = c1;
    e.ip = ip;
    e.b  = b;
    q.push_back(e);
    @(tick_ev);
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    enable = 1'b1;
    cmd_duty = {10'd0, 10'd600};
    cmd_dir = 2'b01;
    rst_n = 1'b1;
    #1;
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_in", int'(in_pair), 0);
    chk("rst_cur", int'(cur_duty), 0);
    chk("rst_busy", int'(busy), 0);

    // ramp-up forward to 600
    tk(0, 0, 4'b0010, 2'b01);
    for (int k = 1; k <= 75; k++) tk(mn(8*k, 600), 0, 4'b0010, 2'b01);
    tk(600, 0, 4'b0010, 2'b01);
    tk(600, 0, 4'b0010, 2'b01);

    // non-multiple target, then ramp down to 300
    cmd_duty[9:0] = 10'd605;
    tk(605, 0, 4'b0010, 2'b01);
    cmd_duty[9:0] = 10'd300;
    for (int k = 1; k <= 39; k++) tk(mx(605-8*k, 300), 0, 4'b0010, 2'b01);

    // back to 600, then reverse
    cmd_duty[9:0] = 10'd600;
    for (int k = 1; k <= 38; k++) tk(mn(300+8*k, 600), 0, 4'b0010, 2'b01);
    cmd_dir[0] = 1'b0;
    tk(600, 0, 4'b0010, 2'b01);
    for (int k = 1; k <= 74; k++) tk(600-8*k, 0, 4'b0010, 2'b01);
    tk(0, 0, 4'b0000, 2'b01);
    tk(0, 0, 4'b0000, 2'b01);
    tk(0, 0, 4'b0000, 2'b00);
    tk(0, 0, 4'b0001, 2'b01);
    for (int k = 1; k <= 75; k++) tk(mn(8*k, 600), 0, 4'b0001, 2'b01);

    // down to 200, then disable
    cmd_duty[9:0] = 10'd200;
    for (int k = 1; k <= 50; k++) tk(mx(600-8*k, 200), 0, 4'b0001, 2'b01);
    enable = 1'b0;
    tk(200, 0, 4'b0001, 2'b01);
    for (int k = 1; k <= 24; k++) tk(200-8*k, 0, 4'b0001, 2'b01);
    tk(0, 0, 4'b0000, 2'b01);
    tk(0, 0, 4'b0000, 2'b01);
    tk(0, 0, 4'b0000, 2'b00);
    tk(0, 0, 4'b0000, 2'b00);

    // abort a reversal during ramp-down
    enable = 1'b1;
    cmd_duty[9:0] = 10'd400;
    tk(0, 0, 4'b0001, 2'b01);
    for (int k = 1; k <= 50; k++) tk(mn(8*k, 400), 0, 4'b0001, 2'b01);
    cmd_dir[0] = 1'b1;
    tk(400, 0, 4'b0001, 2'b01);
    tk(392, 0, 4'b0001, 2'b01);
    tk(384, 0, 4'b0001, 2'b01);
    cmd_dir[0] = 1'b0;
    tk(392, 0, 4'b0001, 2'b01);
    tk(400, 0, 4'b0001, 2'b01);
    tk(400, 0, 4'b0001, 2'b01);

    // asynchronous reset mid-run
    repeat (3) @(negedge clk);
    #2;
    chk("pre_cur0", int'(cur_duty[9:0]), 400);
    chk("pre_pwm0", int'(pwm[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm), 0);
    chk("arst_in", int'(in_pair), 0);
    chk("arst_cur", int'(cur_duty), 0);
    chk("arst_busy", int'(busy), 0);
    q.delete();
    cyc = 0;
    hi0 = 0;
    hi1 = 0;
    prev0 = 0;
    prev1 = 0;
    prev_ip = '0;
    repeat (3) @(negedge clk);
    cmd_duty = {10'd256, 10'd512};
    cmd_dir = 2'b01;
    enable = 1'b1;
    rst_n = 1'b1;

    // two independent channels
    tk(0, 0, 4'b0110, 2'b11);
    for (int k = 1; k <= 66; k++)
      tk(mn(8*k, 512), mn(8*k, 256), 4'b0110, 2'b11);
    tk(512, 256, 4'b0110, 2'b11);

    chk("sb_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
